// File: rtl/data_mem_resp.sv
`default_nettype none
// ---------------------------------------------------------------------------
// data_mem_resp : word-addressed data memory with a fixed-latency response.
// Optional fault detection via DMEM_ACCESS_ERR_EN.           Rev 1.0
// ---------------------------------------------------------------------------
module data_mem_resp #(
  parameter int DEPTH       = 1024,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [3:0]  req_be,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int         AW         = $clog2(DEPTH);
  localparam logic [3:0] c_CNT_INIT = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic        w_enter_resp;
  logic        w_accept;

  logic        r_we;
  logic [31:0] r_addr;
  logic [31:0] r_wdata;
  logic [3:0]  r_be;
  logic [31:0] r_rdata;
  logic        r_err;

  logic [31:0] r_mem [DEPTH];

  logic        w_in_idle;
  logic        w_acc_we;
  logic [31:0] w_acc_addr;
  logic [31:0] w_acc_wdata;
  logic [3:0]  w_acc_be;
  logic        w_acc_err;
  logic        w_wr;
  logic [AW-1:0] w_idx;

  assign w_in_idle = (r_state == S_IDLE);
  assign req_ready = w_in_idle;
  assign w_accept  = req_valid & w_in_idle;
  assign rsp_valid = (r_state == S_RESP);
  assign rsp_rdata = r_rdata;
  assign rsp_err   = r_err;

  // With zero wait cycles the access happens on the accept edge itself,
  // so the live request fields are used instead of the captured copy.
  assign w_acc_we    = w_in_idle ? req_we    : r_we;
  assign w_acc_addr  = w_in_idle ? req_addr  : r_addr;
  assign w_acc_wdata = w_in_idle ? req_wdata : r_wdata;
  assign w_acc_be    = w_in_idle ? req_be    : r_be;
  assign w_idx       = w_acc_addr[AW+1:2];

`ifdef DMEM_ACCESS_ERR_EN
  localparam logic [32:0] c_LIMIT = 33'(DEPTH) << 2;
  assign w_acc_err = (w_acc_addr[1:0] != 2'b00) || ({1'b0, w_acc_addr} >= c_LIMIT);
`else
  logic w_unused_addr;
  assign w_unused_addr = ^{w_acc_addr[1:0], w_acc_addr[31:AW+2]};
  assign w_acc_err     = 1'b0;
`endif

  assign w_wr = w_enter_resp & w_acc_we & ~w_acc_err;

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_enter_resp = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_accept) begin
          if (WAIT_CYCLES == 0) begin
            w_state_nxt  = S_RESP;
            w_enter_resp = 1'b1;
          end else begin
            w_state_nxt = S_WAIT;
            w_cnt_nxt   = c_CNT_INIT;
          end
        end
      end
      S_WAIT: begin
        if (r_cnt == 4'd0) begin
          w_state_nxt  = S_RESP;
          w_enter_resp = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_cnt   <= 4'd0;
      r_we    <= 1'b0;
      r_addr  <= 32'd0;
      r_wdata <= 32'd0;
      r_be    <= 4'd0;
      r_rdata <= 32'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_accept) begin
        r_we    <= req_we;
        r_addr  <= req_addr;
        r_wdata <= req_wdata;
        r_be    <= req_be;
      end
      if (w_enter_resp) begin
        r_err   <= w_acc_err;
        r_rdata <= (w_acc_we || w_acc_err) ? 32'd0 : r_mem[w_idx];
      end
    end
  end

  // Memory array is never reset; reset only blocks a pending commit.
  always_ff @(posedge clk) begin
    if (!rst && w_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (w_acc_be[i]) r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_data_mem_resp.sv
`default_nettype none
// Self-checking bench for data_mem_resp: directed steps plus random traffic
// against a word-array reference model; a second instance runs WAIT_CYCLES=0.
module tb_data_mem_resp;

  localparam int DEPTH = 1024;
  localparam int W     = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic [3:0]  req_be = '0;
  logic        req_ready, rsp_valid, rsp_err;
  logic [31:0] rsp_rdata;

  logic        z_req_valid = 1'b0, z_req_we = 1'b0, z_rsp_ready = 1'b0;
  logic [31:0] z_req_addr = '0, z_req_wdata = '0;
  logic [3:0]  z_req_be = '0;
  logic        z_req_ready, z_rsp_valid, z_rsp_err;
  logic [31:0] z_rsp_rdata;

  int errors = 0;
  int checks = 0;
  logic [31:0] m_mem [DEPTH];

  always #5 clk = ~clk;

  data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(W)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  data_mem_resp #(.DEPTH(DEPTH), .WAIT_CYCLES(0)) u_dut_w0 (
    .clk(clk), .rst(rst), .req_valid(z_req_valid), .req_ready(z_req_ready),
    .req_we(z_req_we), .req_addr(z_req_addr), .req_wdata(z_req_wdata), .req_be(z_req_be),
    .rsp_valid(z_rsp_valid), .rsp_ready(z_rsp_ready), .rsp_rdata(z_rsp_rdata), .rsp_err(z_rsp_err)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference model: returns the expected response and updates the model memory.
  task automatic model(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] be, output logic [31:0] exp_d, output logic exp_e);
    int idx;
    idx = int'((addr >> 2) % DEPTH);
`ifdef DMEM_ACCESS_ERR_EN
    exp_e = (addr[1:0] != 2'b00) || (addr >= 32'(4 * DEPTH));
`else
    exp_e = 1'b0;
`endif
    exp_d = 32'd0;
    if (we) begin
      if (!exp_e)
        for (int b = 0; b < 4; b++)
          if (be[b]) m_mem[idx][8*b +: 8] = wdata[8*b +: 8];
    end else if (!exp_e) begin
      exp_d = m_mem[idx];
    end
  endtask

  // Issue one request, check latency, response payload, hold behaviour and exit bubble.
  task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] be, input int hold, input bit concurrent);
    int n;
    logic [31:0] exp_d;
    logic exp_e;
    n = 0;
    while (!req_ready && n < 20) begin tick(); n++; end
    check("req_ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
    rsp_ready = 1'b0;
    tick();
    req_valid = concurrent;
    model(we, addr, wdata, be, exp_d, exp_e);
    n = 1;
    while (!rsp_valid && n < 40) begin tick(); n++; end
    check("latency", 32'(n), 32'(1 + W));
    check("rdata", rsp_rdata, exp_d);
    check("err", {31'd0, rsp_err}, {31'd0, exp_e});
    for (int h = 0; h < hold; h++) begin
      tick();
      check("hold_valid", {31'd0, rsp_valid}, 32'd1);
      check("hold_ready", {31'd0, req_ready}, 32'd0);
      check("hold_rdata", rsp_rdata, exp_d);
      check("hold_err", {31'd0, rsp_err}, {31'd0, exp_e});
    end
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
    req_valid = 1'b0;
    check("exit_valid", {31'd0, rsp_valid}, 32'd0);
    check("exit_ready", {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    logic        we;
    logic [31:0] addr;
    int          r;

    repeat (3) tick();
    rst = 1'b0;
    tick();
    check("rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err", {31'd0, rsp_err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd1);

    for (int i = 0; i < 32; i++) do_req(1'b1, 32'(i * 4), $urandom, 4'hF, 0, 1'b0);

    do_req(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h10, 32'h0, 4'h0, 0, 1'b0);

    do_req(1'b1, 32'h20, 32'hAABBCCDD, 4'hF, 0, 1'b0);
    do_req(1'b1, 32'h20, 32'h11223344, 4'b0101, 0, 1'b0);
    do_req(1'b0, 32'h20, 32'h0, 4'h0, 0, 1'b0);
    check("merge_direct", m_mem[8], 32'hAA22CC44);

    do_req(1'b0, 32'h10, 32'h0, 4'h0, 5, 1'b1);

    do_req(1'b1, 32'h1000, 32'h12345678, 4'hF, 0, 1'b0);
    do_req(1'b0, 32'h0, 32'h0, 4'h0, 0, 1'b0);

    do_req(1'b1, 32'h24, 32'hFFFFFFFF, 4'h0, 0, 1'b0);
    do_req(1'b0, 32'h24, 32'h0, 4'h0, 0, 1'b0);

    // Reset while a store sits in WAIT: the store must be dropped.
    do_req(1'b1, 32'h40, 32'h0, 4'hF, 0, 1'b0);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'hFFFFFFFF; req_be = 4'hF;
    tick();
    req_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("wait_rst_valid", {31'd0, rsp_valid}, 32'd0);
    check("wait_rst_ready", {31'd0, req_ready}, 32'd1);
    repeat (4) tick();
    check("wait_rst_quiet", {31'd0, rsp_valid}, 32'd0);
    do_req(1'b0, 32'h40, 32'h0, 4'h0, 0, 1'b0);

    for (int t = 0; t < 40; t++) begin
      addr = 32'($urandom_range(0, 31) * 4);
      r = int'($urandom % 8);
      if (r == 0) addr = addr + 32'($urandom_range(1, 3));
      else if (r == 1) addr = addr + 32'h1000 * 32'($urandom_range(1, 3));
      we = 1'($urandom % 2);
      do_req(we, addr, $urandom, 4'($urandom % 16), int'($urandom % 3), 1'b0);
    end

    // Zero-wait instance: back-to-back requests complete every two cycles.
    z_req_valid = 1'b1; z_req_we = 1'b1; z_req_addr = 32'h14;
    z_req_wdata = 32'h5A5A1234; z_req_be = 4'hF; z_rsp_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      if (k == 4) z_req_we = 1'b0;
      check("w0_valid", {31'd0, z_rsp_valid}, 32'(k % 2));
      check("w0_ready", {31'd0, z_req_ready}, 32'((k + 1) % 2));
      if (k % 2 == 1) check("w0_rdata", z_rsp_rdata, (k < 4) ? 32'd0 : 32'h5A5A1234);
      tick();
    end
    z_req_valid = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire

// File: doc/data_mem_resp.md
DATA_MEM_RESP -- requirements
Module: data_mem_resp

Interface
REQ-001 SHALL have parameter DEPTH, default 1024, number of 32-bit words (power of two).
REQ-002 SHALL have parameter WAIT_CYCLES, default 2, extra cycles between request accept and response (0..15).
REQ-003 SHALL have clk  in  1  rising-edge clock; single clock domain.
REQ-004 SHALL have rst  in  1  reset, synchronous, active-high.
REQ-005 SHALL have req_valid  in  1  LSU request present.
REQ-006 SHALL have req_ready  out  1  responder can accept a request.
REQ-007 SHALL have req_we  in  1  1 = store, 0 = load.
REQ-008 SHALL have req_addr  in  32  byte address.
REQ-009 SHALL have req_wdata  in  32  store data, lane-aligned.
REQ-010 SHALL have req_be  in  4  byte enables, bit i = byte lane i.
REQ-011 SHALL have rsp_valid  out  1  response present.
REQ-012 SHALL have rsp_ready  in  1  LSU accepts response.
REQ-013 SHALL have rsp_rdata  out  32  full load word (LSU does lane extraction/extension).
REQ-014 SHALL have rsp_err  out  1  access fault for this response.

Function
REQ-015 SHALL implement FSM IDLE, WAIT, RESP; req_ready=1 only in IDLE.
REQ-016 SHALL accept a request when req_valid & req_ready at a clock edge, capturing we/addr/wdata/be.
REQ-017 On accept, SHALL go to WAIT with counter=WAIT_CYCLES-1 if WAIT_CYCLES>0, else directly to RESP.
REQ-018 In WAIT, SHALL decrement counter each cycle and go to RESP on the edge where counter==0.
REQ-019 SHALL perform the access on the edge entering RESP: store writes enabled lanes only; load registers mem[word] into rsp_rdata.
REQ-020 Word index SHALL be addr[log2(DEPTH)+1:2].
REQ-021 rsp_valid SHALL rise exactly 1+WAIT_CYCLES cycles after the accept edge.
REQ-022 In RESP, rsp_valid, rsp_rdata, rsp_err SHALL stay stable until rsp_valid & rsp_ready; on that edge go to IDLE, rsp_valid=0.
REQ-023 Stores SHALL return rsp_rdata=0; a new request SHALL NOT be accepted in the RESP-exit cycle (one-cycle IDLE bubble).
REQ-024 req_be=0000 on a store SHALL leave memory unchanged and respond with rsp_err=0.
REQ-025 A load after a store to the same word SHALL return the stored data (no forwarding hazard; accesses are serialized).

Reset
REQ-026 On rst: state=IDLE, counter=0, rsp_valid=0, rsp_rdata=0, rsp_err=0; req_ready=1 the cycle after release.
REQ-027 rst SHALL take priority over all transitions; a store captured but not yet committed (in WAIT) SHALL be dropped.
REQ-028 Memory contents SHALL NOT be reset.

Configuration
REQ-029 Macro DMEM_ACCESS_ERR_EN SHALL control fault detection.
REQ-030 With DMEM_ACCESS_ERR_EN: addr[1:0]!=0 or addr>=4*DEPTH SHALL set rsp_err=1, suppress the write, and force rsp_rdata=0.
REQ-031 Without DMEM_ACCESS_ERR_EN: rsp_err SHALL be constant 0, addr[1:0] ignored, upper bits ignored (address wraps modulo DEPTH).

Verification (DEPTH=1024, WAIT_CYCLES=2)
REQ-032 Store 0xDEADBEEF @0x10 be=1111, then load @0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid exactly 3 cycles after each accept.
REQ-033 Word @0x20 = 0xAABBCCDD; store 0x11223344 be=0101; load @0x20 -> 0xAA22CC44.
REQ-034 Load with rsp_ready held 0 for 5 cycles -> rsp_valid/rsp_rdata stable, req_ready=0, a concurrent req_valid not accepted until after response handshake.
REQ-035 Store 0x12345678 @0x1000: with DMEM_ACCESS_ERR_EN -> rsp_err=1, word 0 unchanged; without -> rsp_err=0, load @0x0 returns 0x12345678.
REQ-036 Word @0x40 = 0x0; store 0xFFFFFFFF @0x40, assert rst one cycle after accept (in WAIT) -> rsp_valid=0, state IDLE, subsequent load @0x40 returns 0x0.
REQ-037 WAIT_CYCLES=0 build: load accepted -> rsp_valid next cycle; back-to-back requests with rsp_ready=1 accepted every 2 cycles.
